// File: rtl/neuromorphic_x1_pkg.sv
`default_nettype none
// ============================================================================
// Module   : neuromorphic_x1_pkg
// Brief    : Shared types and field layout for the NEUROMORPHIC_X1 WB bridge.
// Revision : 1.0
// ============================================================================
package neuromorphic_x1_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_PULSE = 3'd1,
        ST_WR_WAIT  = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

    // adr[12] splits the slave into the macro window and the CSR window
    localparam int         c_win_sel_bit   = 12;
    localparam logic [9:0] c_csr_offset    = 10'd0;

    // Layout of the macro write word
    localparam int c_row_msb = 29;
    localparam int c_row_lsb = 25;
    localparam int c_col_msb = 24;
    localparam int c_col_lsb = 20;
    localparam int c_data_w  = 8;

    localparam int c_depth_default = 32;
    localparam int c_pend_w        = 6;

    localparam int c_csr_to_sticky = 31;
    localparam int c_csr_busy      = 30;

endpackage
`default_nettype wire

// File: rtl/nmx1_txn_timer.sv
`default_nettype none
// ============================================================================
// Module   : nmx1_txn_timer
// Brief    : Clear/enable counter flagging expiry after TIMEOUT_CYC cycles.
// Revision : 1.0
// ============================================================================
module nmx1_txn_timer #(
    parameter int TIMEOUT_CYC = 64,
    parameter int TMR_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [TMR_W-1:0] r_count;

    assign expire = enable && (r_count == TMR_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable && !expire) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/neuromorphic_x1_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : neuromorphic_x1_wb_bridge
// Brief    : Wishbone classic slave driving the NEUROMORPHIC_X1 ReRAM macro.
// Revision : 1.0
// ============================================================================
module neuromorphic_x1_wb_bridge
    import neuromorphic_x1_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          DEPTH       = c_depth_default,
    parameter int          TIMEOUT_CYC = 64,
    parameter int          TMR_W       = 8
) (
    input  logic        CLKin,
    input  logic        RSTin,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        mac_en_o,
    output logic        mac_r_wb_o,
    output logic [31:0] mac_di_o,
    output logic [31:0] mac_ad_o,
    output logic [3:0]  mac_sel_o,
    input  logic [31:0] mac_do_i,
    input  logic        mac_ack_i
);

    state_t              r_state;
    logic [c_pend_w-1:0] r_pending;
    logic                r_to_sticky;

    logic        w_hit;
    logic        w_csr_sel;
    logic        w_pend_full;
    logic        w_pend_empty;
    logic        w_tmr_clear;
    logic        w_tmr_en;
    logic        w_expire;
    logic [31:0] w_wr_word;
    logic [31:0] w_csr_word;
    logic        w_unused_dat;

    assign w_hit        = wb_cyc_i && wb_stb_i && (wb_adr_i[31:16] == BASE_ADDR[31:16]);
    assign w_csr_sel    = (wb_adr_i[11:2] == c_csr_offset);
    assign w_pend_full  = (r_pending == c_pend_w'(DEPTH));
    assign w_pend_empty = (r_pending == '0);
    assign w_tmr_clear  = (r_state == ST_IDLE);
    assign w_tmr_en     = (r_state == ST_WR_WAIT) || (r_state == ST_RD_WAIT);
    assign w_unused_dat = ^wb_dat_i[30:c_data_w];

    always_comb begin
        w_wr_word                      = '0;
        w_wr_word[c_row_msb:c_row_lsb] = wb_adr_i[11:7];
        w_wr_word[c_col_msb:c_col_lsb] = wb_adr_i[6:2];
        w_wr_word[c_data_w-1:0]        = wb_dat_i[c_data_w-1:0];
    end

    always_comb begin
        w_csr_word                  = '0;
        w_csr_word[c_csr_to_sticky] = r_to_sticky;
        w_csr_word[c_csr_busy]      = (r_state != ST_IDLE);
        w_csr_word[c_pend_w-1:0]    = r_pending;
    end

    nmx1_txn_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TMR_W       (TMR_W)
    ) u_timer (
        .clk    (CLKin),
        .rst    (RSTin),
        .clear  (w_tmr_clear),
        .enable (w_tmr_en),
        .expire (w_expire)
    );

    always_ff @(posedge CLKin) begin
        if (RSTin) begin
            r_state     <= ST_IDLE;
            r_pending   <= '0;
            r_to_sticky <= 1'b0;
            wb_dat_o    <= '0;
            wb_ack_o    <= 1'b0;
            wb_err_o    <= 1'b0;
            mac_en_o    <= 1'b0;
            mac_r_wb_o  <= 1'b0;
            mac_di_o    <= '0;
            mac_ad_o    <= '0;
            mac_sel_o   <= '0;
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_hit) begin
                        if (wb_adr_i[c_win_sel_bit]) begin
                            if (wb_we_i) begin
                                if (w_csr_sel && wb_dat_i[31]) begin
                                    r_to_sticky <= 1'b0;
                                end
                            end else begin
                                wb_dat_o <= w_csr_sel ? w_csr_word : 32'h0;
                            end
                            wb_ack_o <= 1'b1;
                            r_state  <= ST_RESP;
                        end else if (wb_we_i) begin
                            if (w_pend_full) begin
                                wb_err_o <= 1'b1;
                                r_state  <= ST_RESP;
                            end else begin
                                mac_en_o   <= 1'b1;
                                mac_r_wb_o <= 1'b0;
                                mac_di_o   <= w_wr_word;
                                mac_ad_o   <= wb_adr_i;
                                mac_sel_o  <= wb_sel_i;
                                r_state    <= ST_WR_PULSE;
                            end
                        end else begin
                            // An empty macro queue never acks a read
                            if (w_pend_empty) begin
                                wb_err_o <= 1'b1;
                                r_state  <= ST_RESP;
                            end else begin
                                mac_en_o   <= 1'b1;
                                mac_r_wb_o <= 1'b1;
                                mac_ad_o   <= wb_adr_i;
                                mac_sel_o  <= wb_sel_i;
                                r_state    <= ST_RD_WAIT;
                            end
                        end
                    end
                end
                ST_WR_PULSE: begin
                    // A second EN cycle would enqueue the write twice
                    mac_en_o <= 1'b0;
                    r_state  <= ST_WR_WAIT;
                end
                ST_WR_WAIT: begin
                    if (!wb_cyc_i) begin
                        r_state <= ST_IDLE;
                    end else if (mac_ack_i) begin
                        wb_ack_o <= 1'b1;
                        if (!w_pend_full) begin
                            r_pending <= r_pending + 1'b1;
                        end
                        r_state <= ST_RESP;
                    end else if (w_expire) begin
                        wb_err_o    <= 1'b1;
                        r_to_sticky <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RD_WAIT: begin
                    if (!wb_cyc_i) begin
                        mac_en_o <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else if (mac_ack_i) begin
                        mac_en_o <= 1'b0;
                        wb_dat_o <= mac_do_i;
                        wb_ack_o <= 1'b1;
                        if (!w_pend_empty) begin
                            r_pending <= r_pending - 1'b1;
                        end
                        r_state <= ST_RESP;
                    end else if (w_expire) begin
                        mac_en_o    <= 1'b0;
                        wb_err_o    <= 1'b1;
                        r_to_sticky <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    mac_en_o <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_neuromorphic_x1_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_neuromorphic_x1_wb_bridge
// Brief    : Directed bench with a behavioural ReRAM macro model.
// Revision : 1.0
// ============================================================================
module tb_neuromorphic_x1_wb_bridge;

    localparam logic [31:0] c_csr_adr = 32'h3000_1000;
    localparam int          c_rd_dly  = 44;
    localparam int          c_no_resp = 0;
    localparam int          c_ack     = 1;
    localparam int          c_err     = 2;

    logic        CLKin = 1'b0;
    logic        RSTin;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [31:0] wb_adr_i, wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o;
    logic        mac_en_o, mac_r_wb_o;
    logic [31:0] mac_di_o, mac_ad_o;
    logic [3:0]  mac_sel_o;
    logic [31:0] mac_do_i;
    logic        mac_ack_i;

    int n_checks = 0;
    int n_errors = 0;

    // macro model state
    logic [7:0]  q[$];
    int          wr_cnt, rd_cnt, en_total, both_hi;
    logic        prev_en, noack;
    logic [31:0] en_di, en_ad;
    logic        en_rwb;
    logic [3:0]  en_sel;

    neuromorphic_x1_wb_bridge dut (
        .CLKin      (CLKin),
        .RSTin      (RSTin),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_sel_i   (wb_sel_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .mac_en_o   (mac_en_o),
        .mac_r_wb_o (mac_r_wb_o),
        .mac_di_o   (mac_di_o),
        .mac_ad_o   (mac_ad_o),
        .mac_sel_o  (mac_sel_o),
        .mac_do_i   (mac_do_i),
        .mac_ack_i  (mac_ack_i)
    );

    always #5 CLKin = ~CLKin;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Macro model: write acks 2 cycles after EN, read acks after c_rd_dly EN-high cycles
    initial begin
        mac_ack_i = 1'b0;
        mac_do_i  = '0;
        wr_cnt = 0; rd_cnt = 0; en_total = 0; both_hi = 0; prev_en = 1'b0;
        en_di = '0; en_ad = '0; en_rwb = 1'b0; en_sel = '0;
        forever begin
            @(negedge CLKin);
            mac_ack_i = 1'b0;
            if (wb_ack_o && wb_err_o) both_hi++;
            if (RSTin) begin
                q.delete();
                wr_cnt = 0; rd_cnt = 0; prev_en = 1'b0;
            end else begin
                if (mac_en_o) begin
                    if (!prev_en) begin
                        en_di = mac_di_o; en_ad = mac_ad_o; en_rwb = mac_r_wb_o; en_sel = mac_sel_o;
                    end
                    en_total++;
                end
                prev_en = mac_en_o;
                if (wr_cnt > 0) begin
                    wr_cnt--;
                    if (wr_cnt == 0) mac_ack_i = 1'b1;
                end
                if (mac_en_o && !mac_r_wb_o) begin
                    q.push_back(mac_di_o[7:0]);
                    wr_cnt = 2;
                end
                if (mac_en_o && mac_r_wb_o) begin
                    rd_cnt++;
                    if (rd_cnt == c_rd_dly && !noack) begin
                        mac_ack_i = 1'b1;
                        mac_do_i  = (q.size() > 0) ? {24'h0, q.pop_front()} : 32'h0;
                    end
                end else begin
                    rd_cnt = 0;
                end
            end
        end
    end

    task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       output int resp, output logic [31:0] rdata, output int cycles);
        @(negedge CLKin);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = 4'hF;
        resp = c_no_resp; cycles = 0;
        while (resp == c_no_resp && cycles < 200) begin
            @(negedge CLKin);
            cycles++;
            if (wb_ack_o)      resp = c_ack;
            else if (wb_err_o) resp = c_err;
        end
        rdata = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    int          resp, cyc, e0, n, acks, bad;
    logic [31:0] rd;

    initial begin
        RSTin = 1'b1; noack = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
        repeat (3) @(negedge CLKin);
        check_eq("rst_outputs", {31'd0, |{wb_dat_o, wb_ack_o, wb_err_o, mac_en_o, mac_r_wb_o,
                                          mac_di_o, mac_ad_o, mac_sel_o}}, 32'd0);
        RSTin = 1'b0;

        bus(1'b0, c_csr_adr, 32'h0, resp, rd, cyc);
        check_eq("csr_rst_ack", resp, c_ack);
        check_eq("csr_rst_val", rd, 32'h0000_0000);

        // Address miss: no response, macro untouched
        @(negedge CLKin);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 32'h4000_0884; bad = 0;
        repeat (8) begin
            @(negedge CLKin);
            if (wb_ack_o || wb_err_o || mac_en_o) bad++;
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        check_eq("miss_silent", bad, 0);

        // Single write: row 17, col 1
        e0 = en_total;
        bus(1'b1, 32'h3000_0884, 32'h0000_00A5, resp, rd, cyc);
        check_eq("wr_ack", resp, c_ack);
        check_eq("wr_en_cycles", en_total - e0, 1);
        check_eq("wr_rwb", {31'd0, en_rwb}, 32'd0);
        check_eq("wr_di", en_di, 32'h2210_00A5);
        check_eq("wr_ad", en_ad, 32'h3000_0884);
        check_eq("wr_sel", {28'd0, en_sel}, 32'hF);
        bus(1'b0, c_csr_adr, 32'h0, resp, rd, cyc);
        check_eq("wr_csr", rd, 32'h0000_0001);

        // Read it back
        e0 = en_total;
        bus(1'b0, 32'h3000_0884, 32'h0, resp, rd, cyc);
        check_eq("rd_ack", resp, c_ack);
        check_eq("rd_dat", rd, 32'h0000_00A5);
        check_eq("rd_en_cycles", en_total - e0, c_rd_dly);
        check_eq("rd_en_dropped", {31'd0, mac_en_o}, 32'd0);
        bus(1'b0, c_csr_adr, 32'h0, resp, rd, cyc);
        check_eq("rd_csr", rd, 32'h0000_0000);

        // Read of an empty queue
        e0 = en_total;
        bus(1'b0, 32'h3000_0000, 32'h0, resp, rd, cyc);
        check_eq("empty_err", resp, c_err);
        check_eq("empty_fast", {31'd0, cyc <= 2}, 32'd1);
        check_eq("empty_no_en", en_total - e0, 0);

        // Fill to depth, then overflow
        acks = 0;
        for (int i = 0; i < 32; i++) begin
            bus(1'b1, 32'h3000_0000 + 32'(i * 4), 32'h40 + 32'(i), resp, rd, cyc);
            if (resp == c_ack) acks++;
        end
        check_eq("fill_acks", acks, 32);
        e0 = en_total;
        bus(1'b1, 32'h3000_0000, 32'h77, resp, rd, cyc);
        check_eq("ovf_err", resp, c_err);
        check_eq("ovf_no_en", en_total - e0, 0);
        bus(1'b0, c_csr_adr, 32'h0, resp, rd, cyc);
        check_eq("ovf_csr", rd, 32'h0000_0020);

        // Drain 31 entries, leaving one pending
        for (int i = 0; i < 31; i++) begin
            bus(1'b0, 32'h3000_0000, 32'h0, resp, rd, cyc);
            check_eq($sformatf("drain_%0d", i), rd, 32'h40 + 32'(i));
        end

        // Read with a macro that never acks
        noack = 1'b1;
        @(negedge CLKin);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h3000_0000;
        n = 0;
        while (!mac_en_o && n < 5) begin @(negedge CLKin); n++; end
        n = 0;
        while (!(wb_err_o || wb_ack_o) && n < 200) begin @(negedge CLKin); n++; end
        check_eq("to_err", {31'd0, wb_err_o}, 32'd1);
        check_eq("to_cycles", n, 64);
        check_eq("to_en_low", {31'd0, mac_en_o}, 32'd0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        noack = 1'b0;
        bus(1'b0, c_csr_adr, 32'h0, resp, rd, cyc);
        check_eq("to_csr", rd, 32'h8000_0001);
        bus(1'b1, c_csr_adr, 32'h8000_0000, resp, rd, cyc);
        check_eq("csr_wr_ack", resp, c_ack);
        check_eq("dat_hold", rd, 32'h8000_0001);
        bus(1'b0, c_csr_adr, 32'h0, resp, rd, cyc);
        check_eq("csr_cleared", rd, 32'h0000_0001);

        // Abort a read by dropping cyc
        @(negedge CLKin);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h3000_0000;
        n = 0;
        while (!mac_en_o && n < 5) begin @(negedge CLKin); n++; end
        repeat (10) @(negedge CLKin);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge CLKin);
        check_eq("abort_en_low", {31'd0, mac_en_o}, 32'd0);
        bad = 0;
        repeat (4) begin
            if (wb_ack_o || wb_err_o) bad++;
            @(negedge CLKin);
        end
        check_eq("abort_silent", bad, 0);
        bus(1'b0, c_csr_adr, 32'h0, resp, rd, cyc);
        check_eq("abort_csr", rd, 32'h0000_0001);

        // Reset in the middle of a read
        @(negedge CLKin);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h3000_0000;
        n = 0;
        while (!mac_en_o && n < 5) begin @(negedge CLKin); n++; end
        check_eq("mid_en_high", {31'd0, mac_en_o}, 32'd1);
        repeat (5) @(negedge CLKin);
        RSTin = 1'b1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge CLKin);
        check_eq("mid_rst_outputs", {31'd0, |{wb_dat_o, wb_ack_o, wb_err_o, mac_en_o, mac_r_wb_o,
                                              mac_di_o, mac_ad_o, mac_sel_o}}, 32'd0);
        RSTin = 1'b0;
        bus(1'b0, c_csr_adr, 32'h0, resp, rd, cyc);
        check_eq("mid_rst_csr", rd, 32'h0000_0000);

        check_eq("ack_err_exclusive", both_hi, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
